// File: rtl/beta_pkg.sv
// Shared definitions for the Beta-style fetch path: PCSEL encodings, trap vectors, FSM states.
package beta_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned PCSEL_W = 3;
  localparam int unsigned LIT_W   = 16;

  localparam logic [PCSEL_W-1:0] PCSEL_INC   = 3'd0;
  localparam logic [PCSEL_W-1:0] PCSEL_BR    = 3'd1;
  localparam logic [PCSEL_W-1:0] PCSEL_JT    = 3'd2;
  localparam logic [PCSEL_W-1:0] PCSEL_ILLOP = 3'd3;
  localparam logic [PCSEL_W-1:0] PCSEL_XADR  = 3'd4;

  localparam logic [XLEN-1:0] RESET_VEC = 32'h8000_0000;
  localparam logic [XLEN-1:0] ILLOP_VEC = 32'h8000_0004;
  localparam logic [XLEN-1:0] XADR_VEC  = 32'h8000_0008;

  localparam logic [XLEN-1:0] INSN_BYTES = 32'd4;

  typedef enum logic {
    S_FETCH = 1'b0,
    S_HOLD  = 1'b1
  } fetch_state_e;

  // Word-scaled, sign-extended branch displacement.
  function automatic logic [XLEN-1:0] branch_offset(input logic [LIT_W-1:0] lit);
    return {{(XLEN-LIT_W-2){lit[LIT_W-1]}}, lit, 2'b00};
  endfunction

endpackage

// File: rtl/next_pc_mux.sv
// Next-PC selection: increment, branch, jump (supervisor bit can only be cleared), traps, interrupts.
module next_pc_mux
  import beta_pkg::*;
(
  input  logic [XLEN-1:0]    pc,
  input  logic [LIT_W-1:0]   literal,
  input  logic [XLEN-1:0]    jt,
  input  logic [PCSEL_W-1:0] pcsel,
  input  logic               irq,
  output logic [XLEN-1:0]    next_pc_c,
  output logic               irq_redirect_c
);

  logic [XLEN-1:0] pc_inc;
  logic [1:0]      unused_jt_bits;

  assign pc_inc         = pc + INSN_BYTES;
  assign unused_jt_bits = jt[1:0];

  always_comb begin
    next_pc_c      = ILLOP_VEC;
    irq_redirect_c = irq & ~pc[XLEN-1];
    if (irq_redirect_c) begin
      next_pc_c = XADR_VEC;
    end else begin
      case (pcsel)
        PCSEL_INC:  next_pc_c = pc_inc;
        PCSEL_BR:   next_pc_c = pc_inc + branch_offset(literal);
        PCSEL_JT:   next_pc_c = {pc[XLEN-1] & jt[XLEN-1], jt[XLEN-2:2], 2'b00};
        PCSEL_XADR: next_pc_c = XADR_VEC;
        default:    next_pc_c = ILLOP_VEC;
      endcase
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, fetches over a req/ack handshake, holds the instruction for control.
module instr_fetch_unit
  import beta_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [XLEN-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [XLEN-1:0]    imem_rdata,
  output logic [XLEN-1:0]    instruction,
  output logic               instr_valid,
  input  logic               advance,
  input  logic [PCSEL_W-1:0] pcsel,
  input  logic [XLEN-1:0]    jt,
  input  logic               irq,
  output logic [XLEN-1:0]    pc,
  output logic [XLEN-1:0]    pc_plus4,
  output logic               irq_taken
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] instruction_q, instruction_d;
  logic            imem_req_q, imem_req_d;
  logic            instr_valid_q, instr_valid_d;
  logic            irq_taken_q, irq_taken_d;

  logic [XLEN-1:0] next_pc_c;
  logic            irq_redirect_c;

  next_pc_mux u_next_pc_mux (
    .pc             (pc_q),
    .literal        (instruction_q[LIT_W-1:0]),
    .jt             (jt),
    .pcsel          (pcsel),
    .irq            (irq),
    .next_pc_c      (next_pc_c),
    .irq_redirect_c (irq_redirect_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_FETCH;
      pc_q          <= RESET_VEC;
      instruction_q <= '0;
      imem_req_q    <= 1'b0;
      instr_valid_q <= 1'b0;
      irq_taken_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instruction_q <= instruction_d;
      imem_req_q    <= imem_req_d;
      instr_valid_q <= instr_valid_d;
      irq_taken_q   <= irq_taken_d;
    end
  end

  // An ack only completes a fetch once req is actually on the bus, so a stale
  // ack straight after reset is dropped while the request is being re-issued.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instruction_d = instruction_q;
    imem_req_d    = imem_req_q;
    instr_valid_d = instr_valid_q;
    irq_taken_d   = 1'b0;
    case (state_q)
      S_FETCH: begin
        imem_req_d = 1'b1;
        if (imem_req_q && imem_ack) begin
          instruction_d = imem_rdata;
          instr_valid_d = 1'b1;
          imem_req_d    = 1'b0;
          state_d       = S_HOLD;
        end
      end
      S_HOLD: begin
        if (advance) begin
          pc_d          = next_pc_c;
          irq_taken_d   = irq_redirect_c;
          instr_valid_d = 1'b0;
          imem_req_d    = 1'b1;
          state_d       = S_FETCH;
        end
      end
      default: state_d = S_FETCH;
    endcase
  end

  assign imem_req    = imem_req_q;
  assign imem_addr   = pc_q;
  assign instruction = instruction_q;
  assign instr_valid = instr_valid_q;
  assign pc          = pc_q;
  assign pc_plus4    = pc_q + INSN_BYTES;
  assign irq_taken   = irq_taken_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: directed fetch/advance sequence with hand-computed PCs.
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instruction;
  logic        instr_valid;
  logic        advance;
  logic [2:0]  pcsel;
  logic [31:0] jt;
  logic        irq;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        irq_taken;

  instr_fetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instruction (instruction),
    .instr_valid (instr_valid),
    .advance     (advance),
    .pcsel       (pcsel),
    .jt          (jt),
    .irq         (irq),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .irq_taken   (irq_taken)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] instr;
    logic        irq;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  logic        prev_valid = 1'b0;
  logic        prev_irq = 1'b0;
  logic        seen_irq = 1'b0;
  logic [31:0] last_instr = 32'h0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: each new valid instruction is matched against the next expected fetch.
  always @(negedge clk) begin
    if (irq_taken) begin
      chk("irq_taken_width", 32'(prev_irq), 32'd0);
      seen_irq = 1'b1;
    end
    if (instr_valid && !prev_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got pc %h expected no instruction", pc);
      end else begin
        mon_e = exp_q.pop_front();
        chk("pc", pc, mon_e.addr);
        chk("pc_plus4", pc_plus4, mon_e.addr + 32'd4);
        chk("instruction", instruction, mon_e.instr);
        chk("irq_taken", 32'(seen_irq), 32'(mon_e.irq));
      end
      seen_irq = 1'b0;
    end
    prev_valid = instr_valid;
    prev_irq   = irq_taken;
  end

  task automatic do_fetch(input int wait_n, input logic [31:0] rdata, input logic [31:0] exp_addr,
                          input logic exp_irq, input logic stray_adv);
    exp_t e;
    int   n;
    e.addr  = exp_addr;
    e.instr = rdata;
    e.irq   = exp_irq;
    exp_q.push_back(e);
    n = 0;
    while (!imem_req && n < 20) begin
      tick();
      n++;
    end
    chk("req_seen", 32'(imem_req), 32'd1);
    chk("fetch_addr", imem_addr, exp_addr);
    for (int i = 0; i < wait_n; i++) begin
      advance = stray_adv;
      pcsel   = 3'd4;
      tick();
      chk("req_held", 32'(imem_req), 32'd1);
      chk("addr_stable", imem_addr, exp_addr);
      chk("valid_low", 32'(instr_valid), 32'd0);
    end
    advance    = 1'b0;
    imem_ack   = 1'b1;
    imem_rdata = rdata;
    tick();
    imem_ack   = 1'b0;
    imem_rdata = 32'hDEAD_BEEF;
    last_instr = rdata;
    chk("req_drop", 32'(imem_req), 32'd0);
    chk("valid_rise", 32'(instr_valid), 32'd1);
  endtask

  task automatic do_advance(input logic [2:0] sel, input logic [31:0] jt_v, input logic irq_v);
    int n;
    n = 0;
    while (!instr_valid && n < 20) begin
      tick();
      n++;
    end
    chk("hold_ready", 32'(instr_valid), 32'd1);
    imem_ack   = 1'b1;
    imem_rdata = 32'hBAD0_0BAD;
    tick();
    imem_ack   = 1'b0;
    chk("hold_ack_ignored", instruction, last_instr);
    advance = 1'b1;
    pcsel   = sel;
    jt      = jt_v;
    irq     = irq_v;
    tick();
    advance = 1'b0;
    pcsel   = 3'd3;
    jt      = 32'h5555_5555;
    irq     = 1'b0;
    chk("adv_valid_drop", 32'(instr_valid), 32'd0);
    chk("adv_req_rise", 32'(imem_req), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    advance    = 1'b0;
    pcsel      = 3'd0;
    jt         = 32'h0;
    irq        = 1'b0;
    repeat (3) tick();
    chk("rst_pc", pc, 32'h8000_0000);
    chk("rst_instruction", instruction, 32'h0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_irq_taken", 32'(irq_taken), 32'd0);
    rst = 1'b0;
    tick();
    chk("req_after_rst", 32'(imem_req), 32'd1);
    do_fetch(0, 32'h1234_5678, 32'h8000_0000, 1'b0, 1'b0);

    do_advance(3'd2, 32'h8000_0010, 1'b0);
    do_fetch(0, 32'h7000_FFFE, 32'h8000_0010, 1'b0, 1'b0);
    do_advance(3'd1, 32'h0, 1'b0);
    do_fetch(1, 32'h2222_0000, 32'h8000_000C, 1'b0, 1'b0);
    do_advance(3'd0, 32'h0, 1'b0);
    do_fetch(0, 32'h7000_0003, 32'h8000_0010, 1'b0, 1'b0);
    do_advance(3'd1, 32'h0, 1'b0);
    do_fetch(0, 32'h3333_0000, 32'h8000_0020, 1'b0, 1'b0);

    do_advance(3'd2, 32'h8000_0100, 1'b0);
    do_fetch(0, 32'h4444_0000, 32'h8000_0100, 1'b0, 1'b0);
    do_advance(3'd2, 32'h0000_0403, 1'b0);
    do_fetch(0, 32'h7000_FFFE, 32'h0000_0400, 1'b0, 1'b0);
    do_advance(3'd2, 32'h8000_0000, 1'b0);
    do_fetch(0, 32'h7000_FFFE, 32'h0000_0000, 1'b0, 1'b0);
    do_advance(3'd1, 32'h0, 1'b0);
    do_fetch(0, 32'h5555_0000, 32'hFFFF_FFFC, 1'b0, 1'b0);
    do_advance(3'd0, 32'h0, 1'b0);
    do_fetch(0, 32'h6666_0000, 32'h0000_0000, 1'b0, 1'b0);

    do_advance(3'd2, 32'h0000_0040, 1'b0);
    do_fetch(0, 32'h7777_0000, 32'h0000_0040, 1'b0, 1'b0);
    do_advance(3'd0, 32'h0, 1'b1);
    do_fetch(0, 32'h8888_0000, 32'h8000_0008, 1'b1, 1'b0);
    do_advance(3'd2, 32'h8000_0040, 1'b0);
    do_fetch(0, 32'h9999_0000, 32'h8000_0040, 1'b0, 1'b0);
    do_advance(3'd0, 32'h0, 1'b1);
    do_fetch(0, 32'hAAAA_0000, 32'h8000_0044, 1'b0, 1'b0);

    do_advance(3'd6, 32'h0, 1'b0);
    do_fetch(3, 32'hBBBB_0000, 32'h8000_0004, 1'b0, 1'b1);
    do_advance(3'd4, 32'h0, 1'b0);
    do_fetch(0, 32'hCCCC_0000, 32'h8000_0008, 1'b0, 1'b0);
    do_advance(3'd3, 32'h0, 1'b0);
    do_fetch(2, 32'hCCCC_0001, 32'h8000_0004, 1'b0, 1'b0);
    do_advance(3'd7, 32'h0, 1'b0);
    do_fetch(0, 32'hCCCC_0002, 32'h8000_0004, 1'b0, 1'b0);
    do_advance(3'd5, 32'h0, 1'b0);
    do_fetch(0, 32'hCCCC_0003, 32'h8000_0004, 1'b0, 1'b0);

    do_advance(3'd2, 32'h0000_0100, 1'b0);
    do_fetch(0, 32'hDDDD_0000, 32'h0000_0100, 1'b0, 1'b0);
    do_advance(3'd2, 32'h0000_0200, 1'b1);
    do_fetch(0, 32'hDDDD_0001, 32'h8000_0008, 1'b1, 1'b0);

    // Reset during a wait state, stale ack the cycle after reset.
    do_advance(3'd0, 32'h0, 1'b0);
    chk("abort_addr", imem_addr, 32'h8000_000C);
    tick();
    rst = 1'b1;
    tick();
    chk("abort_req", 32'(imem_req), 32'd0);
    chk("abort_pc", pc, 32'h8000_0000);
    chk("abort_valid", 32'(instr_valid), 32'd0);
    rst        = 1'b0;
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_0001;
    tick();
    imem_ack   = 1'b0;
    chk("stale_ack_valid", 32'(instr_valid), 32'd0);
    chk("restart_req", 32'(imem_req), 32'd1);
    chk("restart_addr", imem_addr, 32'h8000_0000);
    tick();
    chk("restart_wait_valid", 32'(instr_valid), 32'd0);
    do_fetch(1, 32'hEEEE_0000, 32'h8000_0000, 1'b0, 1'b0);

    // Reset while holding an instruction.
    rst = 1'b1;
    tick();
    chk("hold_rst_valid", 32'(instr_valid), 32'd0);
    chk("hold_rst_instruction", instruction, 32'h0);
    rst = 1'b0;
    do_fetch(0, 32'hFFFF_0001, 32'h8000_0000, 1'b0, 1'b0);

    repeat (3) tick();
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
